// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

   // Saturating increment used by the fetch starvation counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                input logic [CNT_W-1:0] limit);
      return (value >= limit) ? limit : value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/arb_latency_counter.sv
// Access-latency timer: loads at grant, counts down, flags terminal count.
module arb_latency_counter
   import mem_arbiter_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Load wins over decrement so every grant restarts the timer cleanly.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)              count <= '0;
      else if (load)          count <= load_value;
      else if (dec && !zero)  count <= count - CNT_W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data port.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | no access in flight; grant on any eligible request
//   ST_ACCESS | latched access driven to memory for LATENCY cycles
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int LATENCY      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [DATA_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read_enable,
   output logic              mem_write_enable,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_t       state;
   arb_owner_t       owner;
   logic [CNT_W-1:0] starve_cnt;
   logic             if_elig;
   logic             dm_elig;
   logic             pick_if;
   logic             grant;
   logic             cnt_zero;

   // A port that is completing this cycle still shows its old request; mask it.
   assign if_elig = if_req & ~if_valid;
   assign dm_elig = dm_req & ~dm_valid;

   // Data port has priority until fetch has been passed over STARVE_LIMIT times.
   assign pick_if = if_elig & (~dm_elig | (starve_cnt == STARVE_MAX));
   assign grant   = (state == ST_IDLE) & (if_elig | dm_elig);

   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_valid;
   assign busy      = (state == ST_ACCESS);

   arb_latency_counter u_lat_cnt (
      .clock      (clock),
      .reset      (reset),
      .load       (grant),
      .load_value (LAT_LOAD),
      .dec        (state == ST_ACCESS),
      .zero       (cnt_zero)
   );

   // Arbitration FSM; the memory strobes and address registers double as the latched request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= ST_IDLE;
         owner            <= OWN_IF;
         starve_cnt       <= '0;
         mem_addr         <= '0;
         mem_write_data   <= '0;
         mem_read_enable  <= 1'b0;
         mem_write_enable <= 1'b0;
         if_valid         <= 1'b0;
         dm_valid         <= 1'b0;
         if_rdata         <= '0;
         dm_rdata         <= '0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state <= ST_ACCESS;
                  if (pick_if) begin
                     owner            <= OWN_IF;
                     mem_addr         <= if_addr;
                     mem_read_enable  <= 1'b1;
                     mem_write_enable <= 1'b0;
                     starve_cnt       <= '0;
                  end else begin
                     owner            <= OWN_DM;
                     mem_addr         <= dm_addr;
                     mem_write_data   <= dm_wdata;
                     mem_read_enable  <= ~dm_we;
                     mem_write_enable <= dm_we;
                     if (if_elig) starve_cnt <= sat_inc(starve_cnt, STARVE_MAX);
                  end
               end
            end
            ST_ACCESS: begin
               if (cnt_zero) begin
                  state            <= ST_IDLE;
                  mem_read_enable  <= 1'b0;
                  mem_write_enable <= 1'b0;
                  if (owner == OWN_IF) begin
                     if_rdata <= mem_read_data;
                     if_valid <= 1'b1;
                  end else begin
                     if (!mem_write_enable) dm_rdata <= mem_read_data;
                     dm_valid <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int LAT  = 2;
   localparam int SLIM = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_read_enable;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;
   logic        stall_if;
   logic        stall_mem;
   logic        busy;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
      .clock            (clock),
      .reset            (reset),
      .if_req           (if_req),
      .if_addr          (if_addr),
      .if_rdata         (if_rdata),
      .if_valid         (if_valid),
      .dm_req           (dm_req),
      .dm_we            (dm_we),
      .dm_addr          (dm_addr),
      .dm_wdata         (dm_wdata),
      .dm_rdata         (dm_rdata),
      .dm_valid         (dm_valid),
      .mem_addr         (mem_addr),
      .mem_write_data   (mem_write_data),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data),
      .stall_if         (stall_if),
      .stall_mem        (stall_mem),
      .busy             (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] init_val(input logic [3:0] i);
      if (i == 4'd4) return 32'h8C01_0004;
      return 32'hA5A5_0000 | {28'h0, i};
   endfunction

   // Physical 16-word memory seen by the DUT (word index = addr[5:2]).
   logic [31:0] phys_mem [16];
   bit   [15:0] phys_written;
   assign mem_read_data = phys_written[mem_addr[5:2]] ? phys_mem[mem_addr[5:2]]
                                                      : init_val(mem_addr[5:2]);
   always @(posedge clock) begin
      if (mem_write_enable) begin
         phys_mem[mem_addr[5:2]]     <= mem_write_data;
         phys_written[mem_addr[5:2]] <= 1'b1;
      end
   end

   // Reference model: one in-flight transaction, completion LAT edges after grant.
   logic [31:0] shadow [16];
   int          m_left;
   bit          m_owner_dm;
   bit          m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   int          m_starve;
   bit          e_if_valid;
   bit          e_dm_valid;
   logic [31:0] e_if_rdata;
   logic [31:0] e_dm_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_left     = 0;
      m_owner_dm = 1'b0;
      m_we       = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_starve   = 0;
      e_if_valid = 1'b0;
      e_dm_valid = 1'b0;
      e_if_rdata = '0;
      e_dm_rdata = '0;
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_edge();
      bit n_if_v = 1'b0;
      bit n_dm_v = 1'b0;
      bit if_el;
      bit dm_el;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            if (!m_owner_dm) begin
               e_if_rdata = shadow[m_addr[5:2]];
               n_if_v     = 1'b1;
            end else begin
               if (m_we) shadow[m_addr[5:2]] = m_wdata;
               else      e_dm_rdata = shadow[m_addr[5:2]];
               n_dm_v = 1'b1;
            end
         end
      end else begin
         if_el = if_req && !e_if_valid;
         dm_el = dm_req && !e_dm_valid;
         if (if_el || dm_el) begin
            if (if_el && (!dm_el || m_starve == SLIM)) begin
               m_owner_dm = 1'b0;
               m_addr     = if_addr;
               m_we       = 1'b0;
               m_starve   = 0;
            end else begin
               m_owner_dm = 1'b1;
               m_addr     = dm_addr;
               m_we       = dm_we;
               m_wdata    = dm_wdata;
               if (if_el) m_starve = (m_starve < SLIM) ? m_starve + 1 : SLIM;
            end
            m_left = LAT;
         end
      end
      e_if_valid = n_if_v;
      e_dm_valid = n_dm_v;
   endtask

   task automatic check_all();
      chk("busy",      {31'b0, busy},             {31'b0, m_left > 0});
      chk("mem_re",    {31'b0, mem_read_enable},  {31'b0, (m_left > 0) && !m_we});
      chk("mem_we",    {31'b0, mem_write_enable}, {31'b0, (m_left > 0) && m_we});
      chk("mem_addr",  mem_addr,                  m_addr);
      chk("mem_wdata", mem_write_data,            m_wdata);
      chk("if_valid",  {31'b0, if_valid},         {31'b0, e_if_valid});
      chk("dm_valid",  {31'b0, dm_valid},         {31'b0, e_dm_valid});
      chk("if_rdata",  if_rdata,                  e_if_rdata);
      chk("dm_rdata",  dm_rdata,                  e_dm_rdata);
      chk("stall_if",  {31'b0, stall_if},         {31'b0, if_req && !e_if_valid});
      chk("stall_mem", {31'b0, stall_mem},        {31'b0, dm_req && !e_dm_valid});
   endtask

   task automatic step();
      model_edge();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic wait_valid(input bit is_dm, input string tag,
                             output int re_cyc, output int we_cyc);
      bit seen = 1'b0;
      re_cyc = 0;
      we_cyc = 0;
      for (int i = 0; i < 16 && !seen; i++) begin
         step();
         if (mem_read_enable)  re_cyc++;
         if (mem_write_enable) we_cyc++;
         seen = is_dm ? dm_valid : if_valid;
      end
      chk(tag, {31'b0, seen}, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (if_req && e_if_valid) if_req = 1'b0;
         if (dm_req && e_dm_valid) dm_req = 1'b0;
         if (!if_req && !dm_req) break;
         step();
      end
      step();
   endtask

   initial begin
      int re_c;
      int we_c;
      int n;
      int n_if_dut;
      int n_if_mdl;
      for (int i = 0; i < 16; i++) shadow[i] = init_val(4'(i));
      reset    = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      model_reset();

      // Reset state
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         check_all();
      end
      @(negedge clock);
      reset = 1'b0;

      // Fetch read of 0x10
      if_req  = 1'b1;
      if_addr = 32'h10;
      wait_valid(1'b0, "fetch_done", re_c, we_c);
      chk("fetch_re_cycles", re_c, 2);
      chk("fetch_rdata", if_rdata, 32'h8C01_0004);
      chk("fetch_mem_addr", mem_addr, 32'h10);
      chk("fetch_stall_at_valid", {31'b0, stall_if}, 32'd0);
      drain();

      // Data write 0xDEADBEEF to 0x20
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h20;
      dm_wdata = 32'hDEAD_BEEF;
      wait_valid(1'b1, "write_done", re_c, we_c);
      chk("write_we_cycles", we_c, 2);
      chk("write_re_cycles", re_c, 0);
      chk("write_rdata_kept", dm_rdata, 32'h0);
      drain();

      // Simultaneous fetch and data read: data first, fetch 3 cycles after dm_valid
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h40;
      if_req  = 1'b1;
      if_addr = 32'h10;
      wait_valid(1'b1, "sim_dm_first", re_c, we_c);
      chk("sim_if_pending", {31'b0, if_valid}, 32'd0);
      chk("sim_dm_rdata", dm_rdata, init_val(4'd0));
      dm_req = 1'b0;
      n = 0;
      for (int i = 0; i < 10 && !if_valid; i++) begin
         step();
         n++;
      end
      chk("sim_if_after_dm", n, 3);
      chk("sim_if_rdata", if_rdata, 32'h8C01_0004);
      drain();

      // Both ports requesting back to back
      n_if_dut = 0;
      n_if_mdl = 0;
      dm_req   = 1'b1;
      dm_we    = 1'b0;
      dm_addr  = 32'h8;
      if_req   = 1'b1;
      if_addr  = 32'h14;
      for (int i = 0; i < 40; i++) begin
         step();
         if (if_valid)   n_if_dut++;
         if (e_if_valid) n_if_mdl++;
         if (e_dm_valid) dm_addr = $urandom() & 32'hFFFF_FFFC;
         if (e_if_valid) if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      chk("contend_fetch_count", n_if_dut, n_if_mdl);
      drain();

      // Reset in the second access cycle of a write, then re-grant
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h24;
      dm_wdata = 32'h1234_5678;
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
      chk("rst_busy",   {31'b0, busy},             32'd0);
      chk("rst_dm_valid", {31'b0, dm_valid},       32'd0);
      chk("rst_mem_addr", mem_addr,                32'h0);
      model_reset();
      check_all();
      @(negedge clock);
      reset = 1'b0;
      step();
      chk("regrant_busy", {31'b0, busy},             32'd1);
      chk("regrant_we",   {31'b0, mem_write_enable}, 32'd1);
      wait_valid(1'b1, "regrant_done", re_c, we_c);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if (if_req && e_if_valid) begin
            if_req = 1'($urandom_range(0, 1));
            if (if_req) if_addr = $urandom() & 32'hFFFF_FFFC;
         end else if (!if_req) begin
            if_addr = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) if_req = 1'b1;
         end
         if (dm_req && e_dm_valid) begin
            dm_req = 1'($urandom_range(0, 1));
            if (dm_req) begin
               dm_addr  = $urandom() & 32'hFFFF_FFFC;
               dm_we    = 1'($urandom_range(0, 1));
               dm_wdata = $urandom();
            end
         end else if (!dm_req) begin
            dm_addr  = $urandom() & 32'hFFFF_FFFC;
            dm_we    = 1'($urandom_range(0, 1));
            dm_wdata = $urandom();
            if ($urandom_range(0, 2) == 0) dm_req = 1'b1;
         end
         step();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
